// File: rtl/spi_tdc_slave_emu.sv
// SPI mode-1 slave that emulates a peripheral register file for loopback self-test.
// SPI pins are oversampled in the clk_clk domain; writes commit to the register file and a strobe port.
module spi_tdc_slave_emu #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              spi_clk,
  input  logic              spi_csn,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] status_in,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;
  localparam logic [CNT_W-1:0]  OP_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0]  DAT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, OPCODE, WDATA, RDATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] csn_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   csn_prev;
  logic                   mosi_d;

  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   csn_rise;
  logic                   csn_fall;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [6:0]             op_sh;
  logic [ADDR_W-1:0]      addr;
  logic [DATA_W-1:0]      wr_sh;
  logic [DATA_W-1:0]      rd_sh;
  logic [DATA_W-1:0]      regs [2**ADDR_W];

  logic [7:0]             op_next;
  logic [DATA_W-1:0]      wr_next;

  assign op_next = {op_sh, mosi_d};
  assign wr_next = {wr_sh[DATA_W-2:0], mosi_d};

  // Synchronizer chains are deliberately not reset so a CSn held low across reset
  // cannot fabricate a falling edge when reset releases.
  always_ff @(posedge clk_clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
    csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    sclk_prev <= sclk_sync[SYNC_STAGES-1];
    csn_prev  <= csn_sync[SYNC_STAGES-1];
    mosi_d    <= mosi_sync[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      csn_rise  <= 1'b0;
      csn_fall  <= 1'b0;
    end else begin
      sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
      sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
      csn_rise  <= csn_sync[SYNC_STAGES-1] & ~csn_prev;
      csn_fall  <= ~csn_sync[SYNC_STAGES-1] & csn_prev;
    end
  end

  // CSn rise is tested before any clock edge so a late deassert always aborts the frame.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      op_sh       <= '0;
      addr        <= '0;
      wr_sh       <= '0;
      rd_sh       <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_valid    <= 1'b0;
      frame_err   <= 1'b0;
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
    end else begin
      wr_valid    <= 1'b0;
      rd_valid    <= 1'b0;
      frame_err   <= 1'b0;
      spi_miso_oe <= ~csn_prev;
      case (state)
        IDLE: begin
          spi_miso <= 1'b0;
          if (csn_fall) begin
            state   <= OPCODE;
            bit_cnt <= '0;
          end
        end
        OPCODE: begin
          spi_miso <= 1'b0;
          if (csn_rise) begin
            state     <= IDLE;
            frame_err <= 1'b1;
          end else if (sclk_fall) begin
            op_sh <= op_next[6:0];
            if (bit_cnt == OP_LAST) begin
              bit_cnt <= '0;
              addr    <= op_next[ADDR_W-1:0];
              if (op_next[7]) begin
                state <= WDATA;
              end else begin
                state <= RDATA;
                if (op_next[ADDR_W-1:0] == TOP_ADDR) rd_sh <= status_in;
                else                                 rd_sh <= regs[op_next[ADDR_W-1:0]];
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        WDATA: begin
          spi_miso <= 1'b0;
          if (csn_rise) begin
            state     <= IDLE;
            frame_err <= 1'b1;
          end else if (sclk_fall) begin
            wr_sh <= wr_next;
            if (bit_cnt == DAT_LAST) begin
              state <= DONE;
              if (addr != TOP_ADDR) begin
                regs[addr] <= wr_next;
                wr_valid   <= 1'b1;
                wr_addr    <= addr;
                wr_data    <= wr_next;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        RDATA: begin
          if (csn_rise) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            spi_miso  <= 1'b0;
          end else if (sclk_rise) begin
            spi_miso <= rd_sh[DATA_W-1];
            rd_sh    <= {rd_sh[DATA_W-2:0], 1'b0};
          end else if (sclk_fall) begin
            if (bit_cnt == DAT_LAST) begin
              state    <= DONE;
              rd_valid <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          spi_miso <= 1'b0;
          if (csn_rise) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          spi_miso <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_tdc_slave_emu.md
# spi_tdc_slave_emu

SPI slave responder that implements the device end of the SPI links driven by the rangefinder's SPI masters (TDC, VGA, APD). It lets the FPGA emulate an SPI peripheral register file for loopback self-test and bring-up without the external chip. SPI pins are oversampled in the system clock domain. Completed writes update an internal register file and are also presented on a strobe port. Reads return register contents or a live status word.

## Interface

Parameters:

- ADDR_W, 3, register address width; 2^ADDR_W registers, top address is read-only status
- DATA_W, 32, register width; must be a multiple of 8
- SYNC_STAGES, 2, synchronizer depth on spi_clk/spi_csn/spi_mosi (≥2)

Ports:

- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset  in  1  synchronous, active-high reset
- spi_clk  in  1  SPI clock from master, mode 1 (CPOL=0, CPHA=1)
- spi_csn  in  1  chip select, active low
- spi_mosi  in  1  master-out data
- spi_miso  out  1  slave-out data
- spi_miso_oe  out  1  MISO output enable; 1 while synchronized CSn low
- status_in  in  DATA_W  live status, returned on read of top address
- wr_valid  out  1  one-cycle strobe on committed write
- wr_addr  out  ADDR_W  address of committed write, valid with wr_valid
- wr_data  out  DATA_W  data of committed write, valid with wr_valid
- rd_valid  out  1  one-cycle strobe when a read frame shifts its last bit
- frame_err  out  1  one-cycle strobe when CSn deasserts mid-frame

## Operation

- Frame layout, MSB first:
  - opcode byte: bit7 = 1 write / 0 read; bits[ADDR_W-1:0] = address; other bits ignored.
  - Then DATA_W data bits.
- Mode 1 framing:
  - MOSI is sampled on falling spi_clk, as detected in the synchronized domain.
  - MISO is updated on rising spi_clk.
- FSM states: IDLE, OPCODE, WDATA, RDATA, DONE.
  - IDLE → OPCODE on synchronized CSn falling edge; bit counter cleared.
  - OPCODE: shift MOSI on each falling edge. After the 8th bit, go to WDATA (bit7=1) or RDATA (bit7=0).
  - Entering RDATA: load the read shift register from regfile[addr], or from a status_in snapshot if addr = 2^ADDR_W-1.
  - RDATA: each rising edge drives the next bit, MSB first. The first rising edge after the opcode drives bit DATA_W-1. Falling edges count bits.
  - RDATA → DONE on the DATA_W-th falling edge; rd_valid pulses.
  - WDATA: shift MOSI on each falling edge. On the DATA_W-th falling edge, go to DONE:
    - writable address: update regfile and pulse wr_valid with wr_addr/wr_data;
    - top address: no update, no wr_valid, no error.
  - DONE: further edges ignored; spi_miso = 0. CSn high → IDLE.
  - Any state except IDLE/DONE: CSn high → IDLE with frame_err pulse. No regfile update, no wr_valid.
- spi_miso is 0 whenever not in RDATA.
- Register file resets to all zeros.

## Timing

- Reset values: spi_miso=0, spi_miso_oe=0, wr_valid=0, rd_valid=0, frame_err=0, wr_addr=0, wr_data=0, state IDLE, all registers 0.
- Pin to edge-detect latency: SYNC_STAGES+1 cycles.
  - wr_valid/rd_valid/frame_err assert SYNC_STAGES+2 cycles after the causing pin edge.
  - wr_addr/wr_data hold until the next commit.
- spi_miso changes SYNC_STAGES+2 cycles after a rising spi_clk.
- Supported rate: f(spi_clk) ≤ f(clk_clk)/8. Each SPI half-period ≥ 4 system cycles.
- spi_status snapshot is taken in the same cycle the 8th opcode bit is sampled.
- Simultaneous events in one synchronized cycle:
  - CSn falling with an spi_clk edge: the clock edge is ignored.
  - CSn rising with the final falling edge: the CSn rise wins, giving frame_err and no commit.
- Reset asserted mid-frame: immediate return to IDLE and all outputs reset. If CSn is still low when reset releases, stay in IDLE until CSn goes high and a fresh falling edge is seen.
- Back-to-back frames: CSn high time ≥ 2×(SYNC_STAGES+1) cycles guarantees detection.

## Test plan

- Write: CSn low, opcode 0x82, data 0xDEADBEEF, CSn high → one wr_valid pulse with wr_addr=2, wr_data=0xDEADBEEF. Subsequent read of addr 2 returns 0xDEADBEEF on MISO.
- Status read: status_in=0x0000_A5C3, opcode 0x07 → MISO 0x0000A5C3 MSB first. rd_valid pulses once. status_in changing after the 8th opcode bit does not affect the returned data.
- Aborted write: opcode 0x81 plus 20 data bits, then CSn high → frame_err pulse, no wr_valid, addr 1 still reads 0x00000000.
- Write to top address: opcode 0x87, data 0x12345678 → no wr_valid, no frame_err. Read of 0x07 returns status_in.
- Overclock frame: after a complete read of addr 2, 8 extra spi_clk cycles are sent → MISO stays 0, no additional strobes, clean return to IDLE on CSn high.
- Reset mid-frame: reset_reset pulsed during WDATA bit 10 with CSn held low and clocks continuing → no wr_valid. Next proper frame after CSn high→low works. All registers read 0.
